// File: rtl/edge_event_scheduler.sv
// Rising-edge detector bank feeding a round-robin, one-at-a-time valid/ready event server.
// Optional sticky per-channel overflow flags are enabled with EDGE_EVENT_SCHED_OVF_EN.
module edge_event_scheduler #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    sig,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N-1:0]    pend,
  output logic [N-1:0]    ovf,
  input  logic            ovf_clr
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sig_dly_q;
  logic [N-1:0]    pend_q, pend_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic            evt_valid_q, evt_valid_d;

  logic [N-1:0]    edge_det;
  logic [N-1:0]    acc_mask;
  logic            hs;
  logic [ID_W-1:0] sel;
  logic            found;

  assign edge_det = sig & ~sig_dly_q;
  assign hs       = (state_q == S_OFFER) && evt_ready;
  assign acc_mask = hs ? ({{(N-1){1'b0}}, 1'b1} << evt_id_q) : '0;

  // First pending channel at or above ptr, wrapping modulo N.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [ID_W:0] j;
      j = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (j >= (ID_W+1)'(N)) j = j - (ID_W+1)'(N);
      if (!found && pend_q[j[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = j[ID_W-1:0];
      end
    end
  end

  // A new edge wins over a same-cycle acceptance, so the flag stays set.
  always_comb pend_d = (pend_q & ~acc_mask) | edge_det;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    evt_id_d    = evt_id_q;
    evt_valid_d = evt_valid_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          evt_id_d    = sel;
          evt_valid_d = 1'b1;
          state_d     = S_OFFER;
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          ptr_d       = (evt_id_q == ID_W'(N-1)) ? '0 : evt_id_q + 1'b1;
          evt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sig_dly loads sig even in reset so inputs already high never fire.
  always_ff @(posedge clk) begin
    sig_dly_q <= sig;
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      ptr_q       <= '0;
      evt_id_q    <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      evt_id_q    <= evt_id_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign pend      = pend_q;
  assign evt_id    = evt_id_q;
  assign evt_valid = evt_valid_q;

`ifdef EDGE_EVENT_SCHED_OVF_EN
  logic [N-1:0] ovf_q, ovf_d;

  // Set beats clear when both happen in one cycle.
  always_comb ovf_d = (ovf_clr ? '0 : ovf_q) | (edge_det & pend_q & ~acc_mask);

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = '0;
`endif

endmodule
